// File: rtl/sha256_nonce_sequencer.sv
// Nonce sweep controller for a looped sha256_transform: issues one nonce per LOOP cycles,
// tracks every issue through the fixed 65-cycle hash latency and reports leading-zero hits.
module sha256_nonce_sequencer #(
  parameter int LOOP  = 4,
  parameter int ZBITS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         job_load,
  input  logic [255:0] job_midstate,
  input  logic [511:0] job_data,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  output logic         busy,
  output logic         done,
  output logic         feedback,
  output logic [5:0]   cnt,
  output logic [255:0] rx_state,
  output logic [511:0] rx_input,
  input  logic [255:0] tx_hash,
  output logic         golden_valid,
  output logic [31:0]  golden_nonce,
  input  logic         golden_ack,
  output logic         overflow
);

  localparam int         LAT        = 65;
  localparam logic [5:0] CNT_MAX    = 6'(LOOP - 1);
  localparam logic [6:0] DRAIN_LAST = 7'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [5:0]     r_cnt;
  logic [6:0]     r_drain;
  logic [31:0]    r_nonce;
  logic [31:0]    r_nonce_end;
  logic [255:0]   r_midstate;
  logic [383:0]   r_data_hi;
  logic [95:0]    r_data_lo;
  logic [LAT-1:0] r_tag_vld;
  logic [31:0]    r_tag_nonce [LAT];
  logic           r_golden_valid;
  logic [31:0]    r_golden_nonce;
  logic           r_overflow;

  logic w_issue;
  logic w_last_issue;
  logic w_hash_zero;
  logic w_hit;
  logic w_unused;

  assign w_issue      = (r_state == S_RUN) && (r_cnt == '0);
  assign w_last_issue = w_issue && (r_nonce == r_nonce_end);
  assign w_hash_zero  = (tx_hash[255 -: ZBITS] == '0);
  // A load on the sample cycle belongs to the aborted job, so its hit is dropped.
  assign w_hit        = r_tag_vld[LAT-1] && w_hash_zero && !job_load;
  assign w_unused     = ^{tx_hash[255-ZBITS:0], job_data[127:96]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_IDLE;
      S_RUN:   if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain == DRAIN_LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (job_load) w_state_nxt = S_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_drain <= '0;
    end else if (job_load) begin
      r_cnt   <= '0;
      r_drain <= '0;
    end else begin
      if ((w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN)) begin
        r_cnt <= (r_cnt == CNT_MAX) ? 6'd0 : r_cnt + 6'd1;
      end else begin
        r_cnt <= '0;
      end
      r_drain <= (r_state == S_DRAIN) ? r_drain + 7'd1 : 7'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_midstate  <= '0;
      r_data_hi   <= '0;
      r_data_lo   <= '0;
      r_nonce     <= '0;
      r_nonce_end <= '0;
    end else if (job_load) begin
      r_midstate  <= job_midstate;
      r_data_hi   <= job_data[511:128];
      r_data_lo   <= job_data[95:0];
      r_nonce     <= nonce_start;
      r_nonce_end <= nonce_end;
    end else if (w_issue) begin
      r_nonce     <= r_nonce + 32'd1;
    end
  end

  // Issue tracking line: stage LAT-1 lines up with the hash of the nonce issued LAT cycles ago.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
    end else if (job_load) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[LAT-2:0], w_issue};
    end
  end

  always_ff @(posedge clk) begin
    r_tag_nonce[0] <= r_nonce;
    for (int i = 1; i < LAT; i++) begin
      r_tag_nonce[i] <= r_tag_nonce[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_golden_valid <= 1'b0;
      r_golden_nonce <= '0;
      r_overflow     <= 1'b0;
    end else begin
      if (w_hit && (!r_golden_valid || golden_ack)) begin
        r_golden_valid <= 1'b1;
        r_golden_nonce <= r_tag_nonce[LAT-1];
      end else if (golden_ack) begin
        r_golden_valid <= 1'b0;
      end
      if (job_load) begin
        r_overflow <= 1'b0;
      end else if (w_hit && r_golden_valid && !golden_ack) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done         = (r_state == S_DONE);
  assign cnt          = r_cnt;
  assign feedback     = (r_cnt != '0);
  assign rx_state     = r_midstate;
  assign rx_input     = {r_data_hi, r_nonce, r_data_lo};
  assign golden_valid = r_golden_valid;
  assign golden_nonce = r_golden_nonce;
  assign overflow     = r_overflow;

endmodule
